// File: rtl/core_pkg.sv
// Shared RV32I encodings for the sequencer and decoder: opcodes, FSM states, mux selects.
// No logic beyond the illegal-encoding helper; pure combinational definitions.
package core_pkg;

    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

`ifdef ILLEGAL_TRAP_EN
    typedef enum logic [2:0] {
        ST_FETCH, ST_DECODE, ST_EXECUTE, ST_MEM, ST_WRITEBACK, ST_TRAP
    } state_e;
`else
    typedef enum logic [2:0] {
        ST_FETCH, ST_DECODE, ST_EXECUTE, ST_MEM, ST_WRITEBACK
    } state_e;
`endif

    typedef enum logic [1:0] {
        PC_SEL_PLUS4 = 2'd0,
        PC_SEL_IMM   = 2'd1,
        PC_SEL_JALR  = 2'd2
    } pc_sel_e;

    typedef enum logic [1:0] {
        WB_ALU  = 2'd0,
        WB_LOAD = 2'd1,
        WB_PC4  = 2'd2,
        WB_IMM  = 2'd3
    } wb_sel_e;

    function automatic logic is_illegal(input logic [6:0] op, input logic [2:0] f3);
        logic ill;
        case (op)
            OP_LOAD:   ill = (f3 == 3'd3) || (f3 >= 3'd6);
            OP_STORE:  ill = (f3 > 3'd2);
            OP_BRANCH: ill = (f3 == 3'd2) || (f3 == 3'd3);
            OP_OP, OP_IMM, OP_JALR, OP_LUI, OP_AUIPC, OP_JAL: ill = 1'b0;
            default:   ill = 1'b1;
        endcase
        return ill;
    endfunction

endpackage

// File: rtl/core_sequencer_if.sv
// Control/memory-handshake bundle between the sequencer (master) and datapath/memory (slave).
// mem_req is held until mem_ready; no other backpressure.
interface core_sequencer_if;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       branch_taken;
    logic       mem_ready;
    logic       mem_req;
    logic       mem_we;
    logic       mem_addr_sel;
    logic       ir_we;
    logic       pc_we;
    logic [1:0] pc_sel;
    logic       rf_we;
    logic [1:0] wb_sel;

    modport master (
        input  opcode, funct3, branch_taken, mem_ready,
        output mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_sel, rf_we, wb_sel
    );

    modport slave (
        output opcode, funct3, branch_taken, mem_ready,
        input  mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_sel, rf_we, wb_sel
    );
endinterface

// File: rtl/retire_counter.sv
// Retired-instruction counter: +1 per enabled cycle, wraps, synchronous reset.
// Count visible one cycle after the enable; no backpressure.
module retire_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] count
);
    logic [W-1:0] count_d, count_q;

    always_comb begin
        count_d = count_q;
        if (en) count_d = count_q + {{(W-1){1'b0}}, 1'b1};
    end

    always_ff @(posedge clk) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end

    assign count = count_q;
endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle RV32I control FSM; fetch/decode/execute/mem/writeback, 3-5 cycles plus memory waits.
// Stalls on mem_ready while requesting memory; ILLEGAL_TRAP_EN adds a sticky TRAP state.
module core_sequencer
    import core_pkg::*;
#(
    parameter int INSTRET_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    core_sequencer_if.master     cs,
    output logic [INSTRET_W-1:0] instret
`ifdef ILLEGAL_TRAP_EN
    ,
    output logic                 illegal_instr
`endif
);
    state_e         state_d, state_q;
    logic           illegal, is_load, is_store, is_branch;
    logic           mem_req, mem_we, mem_addr_sel, ir_we, pc_we, rf_we;
    pc_sel_e        pc_sel;
    wb_sel_e        wb_sel;
    logic [INSTRET_W-1:0] count;

    assign illegal   = is_illegal(cs.opcode, cs.funct3);
    assign is_load   = (cs.opcode == OP_LOAD);
    assign is_store  = (cs.opcode == OP_STORE);
    assign is_branch = (cs.opcode == OP_BRANCH);

    always_comb begin
        state_d      = state_q;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        rf_we        = 1'b0;
        pc_sel       = PC_SEL_PLUS4;
        wb_sel       = WB_ALU;
        case (state_q)
            ST_FETCH: begin
                mem_req = 1'b1;
                if (cs.mem_ready) begin
                    ir_we   = 1'b1;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
`ifdef ILLEGAL_TRAP_EN
                state_d = illegal ? ST_TRAP : ST_EXECUTE;
`else
                state_d = ST_EXECUTE;
`endif
            end
            ST_EXECUTE: begin
                // Illegal encodings fall through to WRITEBACK as a retiring NOP.
                if (illegal) begin
                    state_d = ST_WRITEBACK;
                end else if (is_branch) begin
                    pc_we   = 1'b1;
                    pc_sel  = cs.branch_taken ? PC_SEL_IMM : PC_SEL_PLUS4;
                    state_d = ST_FETCH;
                end else if (is_load || is_store) begin
                    state_d = ST_MEM;
                end else begin
                    state_d = ST_WRITEBACK;
                end
            end
            ST_MEM: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = is_store;
                if (cs.mem_ready) begin
                    pc_we   = is_store;
                    state_d = is_store ? ST_FETCH : ST_WRITEBACK;
                end
            end
            ST_WRITEBACK: begin
                rf_we   = ~illegal;
                pc_we   = 1'b1;
                state_d = ST_FETCH;
                if (!illegal) begin
                    case (cs.opcode)
                        OP_LOAD: wb_sel = WB_LOAD;
                        OP_JAL:  begin wb_sel = WB_PC4; pc_sel = PC_SEL_IMM;  end
                        OP_JALR: begin wb_sel = WB_PC4; pc_sel = PC_SEL_JALR; end
                        OP_LUI:  wb_sel = WB_IMM;
                        default: wb_sel = WB_ALU;
                    endcase
                end
            end
`ifdef ILLEGAL_TRAP_EN
            ST_TRAP: state_d = ST_TRAP;
`endif
            default: state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_FETCH;
        else     state_q <= state_d;
    end

`ifdef ILLEGAL_TRAP_EN
    logic illegal_instr_d, illegal_instr_q;

    always_comb begin
        illegal_instr_d = illegal_instr_q;
        if (state_q == ST_DECODE && illegal) illegal_instr_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) illegal_instr_q <= 1'b0;
        else     illegal_instr_q <= illegal_instr_d;
    end

    assign illegal_instr = illegal_instr_q & ~rst;
`endif

    // Reset masks every output so an abandoned request never reaches the datapath.
    assign cs.mem_req      = mem_req & ~rst;
    assign cs.mem_we       = mem_we & ~rst;
    assign cs.mem_addr_sel = mem_addr_sel & ~rst;
    assign cs.ir_we        = ir_we & ~rst;
    assign cs.pc_we        = pc_we & ~rst;
    assign cs.rf_we        = rf_we & ~rst;
    assign cs.pc_sel       = rst ? 2'b00 : pc_sel;
    assign cs.wb_sel       = rst ? 2'b00 : wb_sel;

    retire_counter #(.W(INSTRET_W)) u_retire (
        .clk   (clk),
        .rst   (rst),
        .en    (cs.pc_we),
        .count (count)
    );

    assign instret = rst ? '0 : count;
endmodule

// File: tb/tb_core_sequencer.sv
// Bench for core_sequencer: directed test-plan cases then random instructions with random waits.
// Expected per-cycle traces are built from instruction-class rules; narrow counter exercises wrap.
module tb_core_sequencer;
    localparam int IW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [IW-1:0] instret;
`ifdef ILLEGAL_TRAP_EN
    logic          illegal_instr;
`endif

    core_sequencer_if sif();

    core_sequencer #(.INSTRET_W(IW)) dut (
        .clk     (clk),
        .rst     (rst),
        .cs      (sif),
        .instret (instret)
`ifdef ILLEGAL_TRAP_EN
        ,
        .illegal_instr (illegal_instr)
`endif
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    int   model_cnt = 0;
    logic exp_ill = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Bit order: req we addr_sel ir_we pc_we pc_sel[1:0] rf_we wb_sel[1:0]
    function automatic logic [9:0] outs();
        return {sif.mem_req, sif.mem_we, sif.mem_addr_sel, sif.ir_we, sif.pc_we,
                sif.pc_sel, sif.rf_we, sif.wb_sel};
    endfunction

    function automatic logic [9:0] ov(input logic req, input logic we, input logic as,
                                      input logic ir, input logic pw, input logic [1:0] ps,
                                      input logic rf, input logic [1:0] wb);
        return {req, we, as, ir, pw, ps, rf, wb};
    endfunction

    function automatic bit legal(input logic [6:0] op, input logic [2:0] f3);
        case (op)
            7'b0000011: return !(f3 inside {3'd3, 3'd6, 3'd7});
            7'b0100011: return f3 <= 3'd2;
            7'b1100011: return !(f3 inside {3'd2, 3'd3});
            7'b0110011, 7'b0010011, 7'b1100111, 7'b0110111, 7'b0010111, 7'b1101111: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] cnt_exp();
        return model_cnt & ((1 << IW) - 1);
    endfunction

    // One clock cycle: drive mem_ready (random noise when no request expected), check, advance.
    task automatic step(input string tag, input logic rdy, input logic [9:0] exp);
        logic has_req;
        has_req = exp[9];
        sif.mem_ready = has_req ? rdy : 1'($urandom);
        @(negedge clk);
        check_eq(tag, outs(), exp);
        check_eq({tag, "_instret"}, instret, cnt_exp());
`ifdef ILLEGAL_TRAP_EN
        check_eq({tag, "_illegal"}, illegal_instr, exp_ill);
`endif
        if (exp[5]) model_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sif.mem_ready = 1'b1;
        @(negedge clk);
        check_eq("rst_outs", outs(), 0);
        check_eq("rst_instret", instret, 0);
`ifdef ILLEGAL_TRAP_EN
        check_eq("rst_illegal", illegal_instr, 0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_cnt = 0;
        exp_ill = 1'b0;
    endtask

    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input int wf,
                             input int wm, input logic tk);
        bit         lg, st;
        logic [1:0] wb, ps;
        sif.opcode = op;
        sif.funct3 = f3;
        sif.branch_taken = tk;
        lg = legal(op, f3);
        for (int i = 0; i < wf; i++) step("fetch_wait", 1'b0, ov(1, 0, 0, 0, 0, 0, 0, 0));
        step("fetch", 1'b1, ov(1, 0, 0, 1, 0, 0, 0, 0));
        step("decode", 1'b0, '0);
`ifdef ILLEGAL_TRAP_EN
        if (!lg) begin
            exp_ill = 1'b1;
            for (int i = 0; i < 3; i++) step("trap", 1'b0, '0);
            do_reset();
            return;
        end
`endif
        if (lg && op == 7'b1100011) begin
            step("br_exec", 1'b0, ov(0, 0, 0, 0, 1, {1'b0, tk}, 0, 0));
            return;
        end
        step("exec", 1'b0, '0);
        if (lg && (op == 7'b0000011 || op == 7'b0100011)) begin
            st = (op == 7'b0100011);
            for (int i = 0; i < wm; i++) step("mem_wait", 1'b0, ov(1, st, 1, 0, 0, 0, 0, 0));
            step("mem", 1'b1, ov(1, st, 1, 0, st, 0, 0, 0));
            if (st) return;
        end
        wb = 2'd0;
        ps = 2'd0;
        if (lg) begin
            if (op == 7'b0000011) wb = 2'd1;
            if (op == 7'b1101111) begin wb = 2'd2; ps = 2'd1; end
            if (op == 7'b1100111) begin wb = 2'd2; ps = 2'd2; end
            if (op == 7'b0110111) wb = 2'd3;
        end
        step("wb", 1'b0, ov(0, 0, 0, 0, 1, ps, lg, wb));
    endtask

    logic [6:0] op_tab [10];

    initial begin
        op_tab = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                   7'b1100111, 7'b0110111, 7'b0010111, 7'b1101111, 7'b1111111};
        rst = 1'b1;
        sif.opcode = 7'h0;
        sif.funct3 = 3'h0;
        sif.branch_taken = 1'b0;
        sif.mem_ready = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        run_instr(7'b0110011, 3'd0, 0, 0, 1'b0);   // ADD
        run_instr(7'b0000011, 3'd2, 2, 3, 1'b0);   // LW with waits
        run_instr(7'b1100011, 3'd0, 0, 0, 1'b1);   // BEQ taken
        run_instr(7'b1100011, 3'd0, 0, 0, 1'b0);   // BEQ not taken
        run_instr(7'b1100111, 3'd0, 0, 0, 1'b0);   // JALR
        run_instr(7'b0100011, 3'd2, 0, 0, 1'b0);   // SW
        run_instr(7'b0110111, 3'd0, 1, 0, 1'b0);   // LUI
        run_instr(7'b1101111, 3'd0, 0, 0, 1'b0);   // JAL
        run_instr(7'b1111111, 3'd0, 0, 0, 1'b0);   // illegal opcode
        run_instr(7'b0000011, 3'd3, 0, 0, 1'b0);   // illegal LOAD funct3

        // Reset during a MEM wait abandons the load.
        sif.opcode = 7'b0000011;
        sif.funct3 = 3'd2;
        step("mr_fetch", 1'b1, ov(1, 0, 0, 1, 0, 0, 0, 0));
        step("mr_decode", 1'b0, '0);
        step("mr_exec", 1'b0, '0);
        step("mr_memwait", 1'b0, ov(1, 0, 1, 0, 0, 0, 0, 0));
        do_reset();
        run_instr(7'b0110011, 3'd0, 0, 0, 1'b0);

        // Sixteen retirements on a 4-bit counter must wrap back to zero.
        do_reset();
        for (int i = 0; i < 16; i++) run_instr(7'b0010011, 3'd0, 0, 0, 1'b0);
        check_eq("wrap", instret, 0);

        for (int i = 0; i < 80; i++) begin
            logic [6:0] op;
            case ($urandom_range(0, 11))
                10:      op = 7'($urandom);
                11:      op = op_tab[9];
                default: op = op_tab[$urandom_range(0, 8)];
            endcase
            run_instr(op, 3'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                      1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
